// File: rtl/bf_pkg.sv
// Shared Bellman-Ford definitions: sequencer state encoding, run-header layout
// in Input Memory, and the node-id/distance widths used by the engines.
package bf_pkg;

    localparam int BF_NODE_W = 8;
    localparam int BF_DIST_W = 16;

    localparam int BF_HDR_SRC_ADDR = 0;
    localparam int BF_HDR_CNT_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_HDR_SRC    = 4'd1,
        ST_HDR_CNT    = 4'd2,
        ST_INIT       = 4'd3,
        ST_INIT_WAIT  = 4'd4,
        ST_PASS       = 4'd5,
        ST_PASS_WAIT  = 4'd6,
        ST_CHECK      = 4'd7,
        ST_CHECK_WAIT = 4'd8,
        ST_DONE       = 4'd9
    } bf_seq_state_t;

endpackage

// File: rtl/bf_pass_sequencer_if.sv
// Sequencer-to-memory/engine bundle: header read port plus init/pass handshakes.
interface bf_pass_sequencer_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    // Handshakes are pulse-based: init_start/pass_start are single-cycle requests,
    // and the engine answers with a single-cycle init_done/pass_done (pass_changed
    // qualified by pass_done) whenever it finishes; a done outside its wait state is dropped.
    logic [AW-1:0] IMAR;
    logic [DW-1:0] IMDR;
    logic [DW-1:0] src_node;
    logic [DW-1:0] num_nodes;
    logic          init_start;
    logic          init_done;
    logic          pass_start;
    logic          check_mode;
    logic          pass_done;
    logic          pass_changed;

    modport master (
        output IMAR, src_node, num_nodes, init_start, pass_start, check_mode,
        input  IMDR, init_done, pass_done, pass_changed
    );

    modport slave (
        input  IMAR, src_node, num_nodes, init_start, pass_start, check_mode,
        output IMDR, init_done, pass_done, pass_changed
    );

endinterface

// File: rtl/bf_pass_sequencer.sv
// Bellman-Ford run scheduler: header read, init, N-1 relaxation passes, negative-cycle check.
// Optional BF_EARLY_EXIT_EN: finish as soon as a relaxation pass reports no change.
module bf_pass_sequencer
    import bf_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    bf_pass_sequencer_if.master   bus,
    output logic [CW-1:0]         pass_count,
    output logic                  busy,
    output logic                  done,
    output logic                  NegCycle,
    output bf_seq_state_t         fsm_state
);

    bf_seq_state_t state, state_next;

    logic [DW-1:0] src_node_q;
    logic [DW-1:0] num_nodes_q;
    logic          neg_cycle_q;

    logic          clear_run;
    logic          count_pass;
    logic          latch_neg;
    logic          init_start_c;
    logic          pass_start_c;
    logic          check_mode_c;

    logic [CW-1:0] pass_count_inc;
    logic [CW-1:0] last_pass;

    assign pass_count_inc = pass_count + CW'(1);
    // num_nodes >= 2 whenever passes run, so N-1 never underflows here
    assign last_pass      = CW'(num_nodes_q) - CW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            src_node_q  <= '0;
            num_nodes_q <= '0;
            pass_count  <= '0;
            neg_cycle_q <= 1'b0;
        end else begin
            state <= state_next;
            if (clear_run) begin
                pass_count  <= '0;
                neg_cycle_q <= 1'b0;
            end
            if (state == ST_HDR_SRC) src_node_q <= bus.IMDR;
            if (state == ST_HDR_CNT) num_nodes_q <= bus.IMDR;
            if (count_pass && (pass_count != '1)) pass_count <= pass_count_inc;
            if (latch_neg) neg_cycle_q <= bus.pass_changed;
        end
    end

    always_comb begin
        state_next   = state;
        clear_run    = 1'b0;
        count_pass   = 1'b0;
        latch_neg    = 1'b0;
        init_start_c = 1'b0;
        pass_start_c = 1'b0;
        check_mode_c = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_HDR_SRC;
                    clear_run  = 1'b1;
                end
            end
            ST_HDR_SRC: state_next = ST_HDR_CNT;
            // A graph of zero or one node has nothing to relax
            ST_HDR_CNT: state_next = (bus.IMDR <= DW'(1)) ? ST_DONE : ST_INIT;
            ST_INIT: begin
                init_start_c = 1'b1;
                state_next   = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (bus.init_done) state_next = ST_PASS;
            end
            ST_PASS: begin
                pass_start_c = 1'b1;
                state_next   = ST_PASS_WAIT;
            end
            ST_PASS_WAIT: begin
                if (bus.pass_done) begin
                    count_pass = 1'b1;
`ifdef BF_EARLY_EXIT_EN
                    if (!bus.pass_changed)                state_next = ST_DONE;
                    else if (pass_count_inc == last_pass) state_next = ST_CHECK;
                    else                                  state_next = ST_PASS;
`else
                    if (pass_count_inc == last_pass) state_next = ST_CHECK;
                    else                             state_next = ST_PASS;
`endif
                end
            end
            ST_CHECK: begin
                pass_start_c = 1'b1;
                check_mode_c = 1'b1;
                state_next   = ST_CHECK_WAIT;
            end
            ST_CHECK_WAIT: begin
                check_mode_c = 1'b1;
                if (bus.pass_done) begin
                    latch_neg  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.IMAR       = (state == ST_HDR_CNT) ? AW'(BF_HDR_CNT_ADDR) : AW'(BF_HDR_SRC_ADDR);
    assign bus.src_node   = src_node_q;
    assign bus.num_nodes  = num_nodes_q;
    assign bus.init_start = init_start_c;
    assign bus.pass_start = pass_start_c;
    assign bus.check_mode = check_mode_c;

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign NegCycle  = neg_cycle_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_bf_pass_sequencer.sv
// Directed bench for bf_pass_sequencer: header read, pass scheduling, reset, stray handshakes.
module tb_bf_pass_sequencer;
    import bf_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] pass_count;
    logic          busy;
    logic          done;
    logic          NegCycle;
    bf_seq_state_t fsm_state;

    logic [DW-1:0] hdr_src = '0;
    logic [DW-1:0] hdr_cnt = '0;

    int vectors      = 0;
    int miscompares  = 0;
    int n_init_pulse = 0;
    int n_pass_pulse = 0;

    bf_pass_sequencer_if #(.AW(AW), .DW(DW)) bus();

    bf_pass_sequencer #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .pass_count (pass_count),
        .busy       (busy),
        .done       (done),
        .NegCycle   (NegCycle),
        .fsm_state  (fsm_state)
    );

    always #5 clock = ~clock;

    // Asynchronous-read header memory
    assign bus.IMDR = (bus.IMAR == AW'(0)) ? hdr_src :
                      (bus.IMAR == AW'(1)) ? hdr_cnt : 8'hEE;

    always @(posedge clock) begin
        if (bus.init_start === 1'b1) n_init_pulse++;
        if (bus.pass_start === 1'b1) n_pass_pulse++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_run(input logic [DW-1:0] src, input logic [DW-1:0] cnt, input bit hold);
        hdr_src = src;
        hdr_cnt = cnt;
        start   = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        check("hdr_src_state", 32'(fsm_state), 32'(ST_HDR_SRC));
        check("hdr_src_imar", 32'(bus.IMAR), 0);
        check("run_clears_done", 32'(done), 0);
        check("run_clears_neg", 32'(NegCycle), 0);
        check("run_clears_count", 32'(pass_count), 0);
        check("hdr_busy", 32'(busy), 1);
        tick();
        check("hdr_cnt_imar", 32'(bus.IMAR), 1);
        check("src_latched", 32'(bus.src_node), 32'(src));
        tick();
        check("num_latched", 32'(bus.num_nodes), 32'(cnt));
    endtask

    task automatic ack_init(input int dly);
        for (int i = 0; i < 20 && bus.init_start !== 1'b1; i++) tick();
        check("init_start_seen", 32'(bus.init_start), 1);
        tick();
        check("init_start_1cyc", 32'(bus.init_start), 0);
        for (int i = 1; i < dly; i++) tick();
        bus.init_done = 1'b1;
        tick();
        bus.init_done = 1'b0;
    endtask

    task automatic do_pass(input logic exp_chk, input logic chg, input int dly,
                           input int exp_cnt, output int waited);
        int w;
        w = 0;
        while (w < 40 && bus.pass_start !== 1'b1) begin
            tick();
            w++;
        end
        check("pass_start_seen", 32'(bus.pass_start), 1);
        check("check_mode_start", 32'(bus.check_mode), 32'(exp_chk));
        tick();
        check("check_mode_wait", 32'(bus.check_mode), 32'(exp_chk));
        check("pass_start_1cyc", 32'(bus.pass_start), 0);
        for (int i = 1; i < dly; i++) tick();
        bus.pass_done    = 1'b1;
        bus.pass_changed = chg;
        tick();
        bus.pass_done    = 1'b0;
        bus.pass_changed = 1'b0;
        check("pass_count", 32'(pass_count), 32'(exp_cnt));
        waited = w;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
        check({tag, "_imar"}, 32'(bus.IMAR), 0);
        check({tag, "_src"}, 32'(bus.src_node), 0);
        check({tag, "_num"}, 32'(bus.num_nodes), 0);
        check({tag, "_count"}, 32'(pass_count), 0);
        check({tag, "_flags"}, {26'd0, busy, done, NegCycle, bus.init_start,
                                bus.pass_start, bus.check_mode}, 0);
    endtask

    initial begin
        int w;
        int ni;
        int np;
        bus.init_done    = 1'b0;
        bus.pass_done    = 1'b0;
        bus.pass_changed = 1'b0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_all_zero("idle");

        // N=5, src=0, engines answer 3 cycles after each request
        ni = n_init_pulse;
        np = n_pass_pulse;
        begin_run(8'd0, 8'd5, 1'b0);
        ack_init(3);
        for (int p = 1; p <= 4; p++) do_pass(1'b0, 1'b1, 3, p, w);
        do_pass(1'b1, 1'b0, 3, 4, w);
        check("t1_done", 32'(done), 1);
        check("t1_neg", 32'(NegCycle), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_init_pulses", 32'(n_init_pulse - ni), 1);
        check("t1_pass_pulses", 32'(n_pass_pulse - np), 5);
        tick();
        check("t1_done_held", 32'(done), 1);

        // N=4, instant init ack, check pass finds an improvement
        np = n_pass_pulse;
        begin_run(8'd2, 8'd4, 1'b0);
        ack_init(1);
        do_pass(1'b0, 1'b1, 3, 1, w);
        check("t2_first_pass_latency", 32'(w), 0);
        do_pass(1'b0, 1'b1, 2, 2, w);
        do_pass(1'b0, 1'b1, 1, 3, w);
        do_pass(1'b1, 1'b1, 2, 3, w);
        check("t2_done", 32'(done), 1);
        check("t2_neg", 32'(NegCycle), 1);
        check("t2_pass_pulses", 32'(n_pass_pulse - np), 4);

        // N=1 then N=0: straight to DONE without engine activity
        ni = n_init_pulse;
        np = n_pass_pulse;
        begin_run(8'd7, 8'd1, 1'b0);
        check("t3_n1_state", 32'(fsm_state), 32'(ST_DONE));
        check("t3_n1_done", 32'(done), 1);
        check("t3_n1_neg", 32'(NegCycle), 0);
        begin_run(8'd3, 8'd0, 1'b0);
        check("t3_n0_done", 32'(done), 1);
        check("t3_n0_neg", 32'(NegCycle), 0);
        tick();
        check("t3_init_pulses", 32'(n_init_pulse - ni), 0);
        check("t3_pass_pulses", 32'(n_pass_pulse - np), 0);

        // N=6, reset during the second pass, late acks afterwards
        begin_run(8'd5, 8'd6, 1'b0);
        ack_init(2);
        do_pass(1'b0, 1'b1, 2, 1, w);
        for (int i = 0; i < 20 && bus.pass_start !== 1'b1; i++) tick();
        check("t4_p2_start", 32'(bus.pass_start), 1);
        tick();
        check("t4_p2_wait", 32'(fsm_state), 32'(ST_PASS_WAIT));
        reset = 1'b1;
        tick();
        check_all_zero("t4_reset");
        reset            = 1'b0;
        bus.pass_done    = 1'b1;
        bus.pass_changed = 1'b1;
        bus.init_done    = 1'b1;
        tick();
        bus.pass_done    = 1'b0;
        bus.pass_changed = 1'b0;
        bus.init_done    = 1'b0;
        check_all_zero("t4_late_ack");

        // N=3 with start held high and a stray pass_done in INIT_WAIT
        ni = n_init_pulse;
        np = n_pass_pulse;
        begin_run(8'd9, 8'd3, 1'b1);
        check("t5_init", 32'(fsm_state), 32'(ST_INIT));
        tick();
        bus.pass_done    = 1'b1;
        bus.pass_changed = 1'b1;
        tick();
        bus.pass_done    = 1'b0;
        bus.pass_changed = 1'b0;
        check("t5_stray_state", 32'(fsm_state), 32'(ST_INIT_WAIT));
        check("t5_stray_count", 32'(pass_count), 0);
        bus.init_done = 1'b1;
        tick();
        bus.init_done = 1'b0;
        do_pass(1'b0, 1'b1, 2, 1, w);
        do_pass(1'b0, 1'b1, 2, 2, w);
        do_pass(1'b1, 1'b0, 2, 2, w);
        start = 1'b0;
        check("t5_done", 32'(done), 1);
        check("t5_neg", 32'(NegCycle), 0);
        check("t5_init_pulses", 32'(n_init_pulse - ni), 1);
        check("t5_pass_pulses", 32'(n_pass_pulse - np), 3);
        tick();
        check("t5_stays_done", 32'(fsm_state), 32'(ST_DONE));

`ifdef BF_EARLY_EXIT_EN
        // N=8, second pass reports convergence
        np = n_pass_pulse;
        begin_run(8'd1, 8'd8, 1'b0);
        ack_init(1);
        do_pass(1'b0, 1'b1, 2, 1, w);
        do_pass(1'b0, 1'b0, 2, 2, w);
        check("t6_done", 32'(done), 1);
        check("t6_neg", 32'(NegCycle), 0);
        check("t6_pass_pulses", 32'(n_pass_pulse - np), 2);
`else
        // N=4, unchanged passes still run the full schedule
        np = n_pass_pulse;
        begin_run(8'd1, 8'd4, 1'b0);
        ack_init(1);
        do_pass(1'b0, 1'b0, 2, 1, w);
        do_pass(1'b0, 1'b0, 2, 2, w);
        do_pass(1'b0, 1'b1, 2, 3, w);
        do_pass(1'b1, 1'b0, 2, 3, w);
        check("t6_done", 32'(done), 1);
        check("t6_neg", 32'(NegCycle), 0);
        check("t6_pass_pulses", 32'(n_pass_pulse - np), 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
